// File: rtl/mips_dbg_pkg.sv
// Shared types for the MIPS run-and-dump debug sequencer.
package mips_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_DUMP_REG = 3'd2,
        ST_DUMP_MEM = 3'd3,
        ST_DONE     = 3'd4
    } dbg_state_t;

    // Dump index width: wide enough to address the larger of the two dumped spaces.
    function automatic int DBG_IDX_W(input int reg_count, input int mem_depth);
        int w_reg;
        int w_mem;
        w_reg = $clog2(reg_count);
        w_mem = $clog2(mem_depth);
        if (w_reg < 1) begin
            w_reg = 1;
        end else begin
            w_reg = w_reg;
        end
        return (w_reg > w_mem) ? w_reg : w_mem;
    endfunction

endpackage

// File: rtl/mips_run_dump_ctrl_counter.sv
// Loadable down counter with zero and one detect, used for the remaining run length.
module dbg_down_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_is_one,
    output logic         o_is_zero
);

    logic [W-1:0] r_count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_is_one  = (r_count == W'(1));
    assign o_is_zero = (r_count == '0);

endmodule

// File: rtl/mips_run_dump_ctrl.sv
// Runs the MIPS core for a programmed number of cycles, then streams out the
// register file and data memory as a valid/ready word sequence.
module mips_run_dump_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    parameter int MEM_DEPTH = 256,
    parameter int CYC_W     = 16
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic [CYC_W-1:0]                               cycle_count,
    output logic                                           cpu_step_en,
    output logic [$clog2(REG_COUNT)-1:0]                   reg_rd_addr,
    input  logic [DATA_W-1:0]                              reg_rd_data,
    output logic [$clog2(MEM_DEPTH)-1:0]                   mem_rd_addr,
    input  logic [DATA_W-1:0]                              mem_rd_data,
    output logic                                           dump_valid,
    input  logic                                           dump_ready,
    output logic [DATA_W-1:0]                              dump_data,
    output logic                                           dump_is_mem,
    output logic [DBG_IDX_W(REG_COUNT, MEM_DEPTH)-1:0]     dump_addr,
    output logic                                           dump_last,
    output logic                                           busy,
    output logic                                           done
);

    localparam int IDX_W  = DBG_IDX_W(REG_COUNT, MEM_DEPTH);
    localparam int REG_AW = $clog2(REG_COUNT);
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);

    dbg_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_step_en;
    logic             r_valid;
    logic             r_is_mem;
    logic             r_last;
    logic             r_busy;
    logic             r_done;

    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_one;
    logic w_cnt_zero;

    assign w_cnt_load = (r_state == ST_IDLE) && start;
    assign w_cnt_dec  = (r_state == ST_RUN) && !w_cnt_zero;

    dbg_down_counter #(.W(CYC_W)) u_remaining (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (cycle_count),
        .i_dec      (w_cnt_dec),
        .o_is_one   (w_cnt_one),
        .o_is_zero  (w_cnt_zero)
    );

    // Sequencer FSM; every visible control output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_step_en <= 1'b0;
            r_valid   <= 1'b0;
            r_is_mem  <= 1'b0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        r_idx  <= '0;
                        if (cycle_count != '0) begin
                            r_state   <= ST_RUN;
                            r_step_en <= 1'b1;
                        end else begin
                            r_state <= ST_DUMP_REG;
                            r_valid <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // A zero count here can only come from corruption; leave RUN anyway.
                    if (w_cnt_one || w_cnt_zero) begin
                        r_state   <= ST_DUMP_REG;
                        r_step_en <= 1'b0;
                        r_valid   <= 1'b1;
                        r_idx     <= '0;
                    end
                end
                ST_DUMP_REG: begin
                    if (dump_ready) begin
                        if (r_idx == REG_LAST) begin
                            r_state  <= ST_DUMP_MEM;
                            r_idx    <= '0;
                            r_is_mem <= 1'b1;
                            r_last   <= (MEM_LAST == '0);
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_DUMP_MEM: begin
                    if (dump_ready) begin
                        if (r_idx == MEM_LAST) begin
                            r_state  <= ST_DONE;
                            r_idx    <= '0;
                            r_valid  <= 1'b0;
                            r_is_mem <= 1'b0;
                            r_last   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_idx  <= r_idx + IDX_W'(1);
                            r_last <= ((r_idx + IDX_W'(1)) == MEM_LAST);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_idx     <= '0;
                    r_step_en <= 1'b0;
                    r_valid   <= 1'b0;
                    r_is_mem  <= 1'b0;
                    r_last    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Read data is combinational from the core, so the word mux cannot be registered.
    assign dump_data   = r_is_mem ? mem_rd_data : reg_rd_data;
    assign reg_rd_addr = (r_valid && !r_is_mem) ? r_idx[REG_AW-1:0] : '0;
    assign mem_rd_addr = (r_valid && r_is_mem) ? r_idx[MEM_AW-1:0] : '0;
    assign dump_addr   = r_idx;
    assign dump_valid  = r_valid;
    assign dump_is_mem = r_is_mem;
    assign dump_last   = r_last;
    assign cpu_step_en = r_step_en;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: doc/mips_run_dump_ctrl.md
# mips_run_dump_ctrl

Synthesizable run-and-dump sequencer for the single-cycle MIPS core. It gates the core's clock enable for a programmed number of cycles, then scans out the register file and data memory as a valid/ready word stream. Benches and on-board debug can capture final architectural state without hierarchical `$writememb` access. It sits beside the MIPS top level and connects to the register-file and data-memory read ports through a debug mux.

## Interface
Parameters:
- `DATA_W`, 32, width of register and memory words
- `REG_COUNT`, 32, number of registers dumped (addresses 0..REG_COUNT-1)
- `MEM_DEPTH`, 256, number of data-memory words dumped (addresses 0..MEM_DEPTH-1)
- `CYC_W`, 16, width of the run-length counter

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `start` in 1: begin a run; sampled only in IDLE
- `cycle_count` in CYC_W: number of CPU cycles to run; sampled with `start`
- `cpu_step_en` out 1: clock enable to the MIPS core
- `reg_rd_addr` out $clog2(REG_COUNT): debug read address to the register file
- `reg_rd_data` in DATA_W: combinational read data from the register file
- `mem_rd_addr` out $clog2(MEM_DEPTH): debug read address to data memory
- `mem_rd_data` in DATA_W: combinational read data from data memory
- `dump_valid` out 1: dump word available
- `dump_ready` in 1: consumer accepts the word
- `dump_data` out DATA_W: dumped word
- `dump_is_mem` out 1: 0 means the word is a register, 1 means it is memory
- `dump_addr` out $clog2(MEM_DEPTH) (or REG_COUNT, whichever is wider): index of the current word
- `dump_last` out 1: high on the final memory word
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse when the dump completes

## Operation
- FSM states: IDLE, RUN, DUMP_REG, DUMP_MEM, DONE.
- IDLE, `start`=1: latch `cycle_count` into `remaining`.
  - If `cycle_count`≠0, go to RUN.
  - Otherwise go directly to DUMP_REG.
- RUN:
  - `cpu_step_en`=1; `remaining` decrements each cycle.
  - When `remaining`==1 (the last enabled cycle), go to DUMP_REG with the index cleared to 0.
  - Exactly `cycle_count` enabled cycles occur.
- DUMP_REG:
  - `dump_valid`=1, `dump_is_mem`=0.
  - `reg_rd_addr`=`dump_addr`=index; `dump_data`=`reg_rd_data`.
  - On `dump_valid && dump_ready` the index increments.
  - On acceptance of index REG_COUNT-1, go to DUMP_MEM with the index cleared to 0.
- DUMP_MEM:
  - Same handshake, sourcing `mem_rd_data` via `mem_rd_addr`.
  - `dump_last`=1 when index==MEM_DEPTH-1.
  - Acceptance of the last word goes to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` in any state other than IDLE is ignored; `cycle_count` changes after sampling have no effect.
- Outside RUN, `cpu_step_en`=0, so the core state is frozen while the dump reads it.
- Read addresses drive 0 outside the DUMP states.
- Index width arithmetic: the counter is sized for the larger of REG_COUNT and MEM_DEPTH. Wrap-around never occurs because terminal compares use count-1.

## Timing
- Reset values: state=IDLE; `cpu_step_en`=0, `dump_valid`=0, `dump_last`=0, `dump_is_mem`=0, `busy`=0, `done`=0; `dump_addr`=0, `reg_rd_addr`=0, `mem_rd_addr`=0, `dump_data`=reg_rd_data of address 0 (don't-care while `dump_valid`=0).
- `rst_n` asserted mid-run or mid-dump: return to IDLE immediately (asynchronously) and drop `cpu_step_en` and `dump_valid` with no completion pulse.
- Latency:
  - `start` to first `cpu_step_en`: 1 cycle.
  - Last enabled cycle to first `dump_valid`: 1 cycle.
  - Final acceptance to `done`: 1 cycle.
- Handshake:
  - `dump_valid` never drops without acceptance.
  - `dump_data`, `dump_addr`, `dump_is_mem` and `dump_last` are stable while `dump_valid && !dump_ready`.
- With `dump_ready` held high, one word transfers per cycle. The total from `start` to `done` is 1 + cycle_count + REG_COUNT + MEM_DEPTH + 1 cycles.

## Structure
- Shared package `mips_dbg_pkg`: state enum `dbg_state_t` and the `DBG_IDX_W` width function.
- One natural sub-module, `dbg_down_counter`, covering load/decrement/zero-detect for `remaining`.
- The dump index stays inline in the FSM.

## Test plan
- `cycle_count`=3, `dump_ready`=1 → `cpu_step_en` high for exactly 3 cycles, then 32 register words followed by 256 memory words. `dump_last` is high only on memory address 255, and `done` pulses at cycle 1+3+288+1.
- `cycle_count`=0 → no `cpu_step_en`; the dump starts the cycle after `start`.
- Preload R5=0x0000_00AA and memory[10]=0xDEAD_BEEF, run 0 cycles → the word with `dump_is_mem`=0 at address 5 is 0xAA, and the word with `dump_is_mem`=1 at address 10 is 0xDEADBEEF.
- Random `dump_ready` (50%) → every word appears exactly once, in order. Outputs are held stable during stalls, and the word count is 288.
- `start` pulsed during RUN and DUMP_MEM → ignored; a single `done` pulse occurs.
- `rst_n` dropped during DUMP_REG at index 7 → immediate return to IDLE with all outputs at reset values. A new `start` then begins cleanly from index 0.
